pbus_timeout_bridge: RTL and testbench

Registered bridge on the native peripheral bus, placed between the data-bus splitter's peripheral output and the peripheral-bus splitter. It holds one outstanding CPU request at a time and presents a stable registered request to the peripherals. It returns the peripheral response registered. If a peripheral fails to answer within a bounded number of cycles, it terminates the transaction with an error word and latches the failing address. This stops a hung or unmapped peripheral from stalling the CPU forever.

---
 rtl/pbus_timeout_bridge.sv | 146 ++++++++++++++
 tb/tb_pbus_timeout_bridge.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pbus_timeout_bridge.sv
// pbus_timeout_bridge
//   Registered bridge on the native peripheral bus. It holds one outstanding
//   CPU request and presents it, registered, to the peripheral splitter. The
//   peripheral response comes back registered. If the peripheral does not
//   answer within TIMEOUT cycles, the transaction ends with ERR_VALUE as read
//   data, and the failing address is latched.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-low reset
//   m_req   in   upstream request   {valid, addr, wdata, wstrb}
//   m_resp  out  upstream response  {rdata, ready}
//   s_req   out  downstream request {valid, addr, wdata, wstrb}
//   s_resp  in   downstream response {rdata, ready}
//   to_clr  in   clears to_flag / to_addr
//   to_flag out  sticky timeout indicator
//   to_addr out  address of the most recent timed-out request
module pbus_timeout_bridge #(
    parameter int                  ADDR_W    = 32,
    parameter int                  DATA_W    = 32,
    parameter int                  TIMEOUT   = 256,
    parameter logic [DATA_W-1:0]   ERR_VALUE = 32'hDEAD_BEEF,
    localparam int                 REQ_W     = 1 + ADDR_W + DATA_W + DATA_W/8,
    localparam int                 RESP_W    = DATA_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQ_W-1:0]  m_req,
    output logic [RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]  s_req,
    input  logic [RESP_W-1:0] s_resp,
    input  logic              to_clr,
    output logic              to_flag,
    output logic [ADDR_W-1:0] to_addr
);

    localparam int SW = DATA_W / 8;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Unpacked bus fields
    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic              s_ready;
    logic [DATA_W-1:0] s_rdata;

    assign m_valid = m_req[REQ_W-1];
    assign m_addr  = m_req[REQ_W-2 -: ADDR_W];
    assign m_wdata = m_req[SW+DATA_W-1 -: DATA_W];
    assign m_wstrb = m_req[SW-1:0];
    assign s_ready = s_resp[0];
    assign s_rdata = s_resp[RESP_W-1:1];

    logic [1:0]        state_q,  state_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [SW-1:0]     wstrb_q,  wstrb_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              flag_q,   flag_d;
    logic [ADDR_W-1:0] toaddr_q, toaddr_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rdata_d  = rdata_q;
        flag_d   = flag_q;
        toaddr_d = toaddr_q;

        // Clear first so a timeout in the same cycle overrides it below.
        if (to_clr) begin
            flag_d   = 1'b0;
            toaddr_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (m_valid) begin
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    wstrb_d = m_wstrb;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A slave answer takes priority over an expiring counter.
                if (s_ready) begin
                    rdata_d = s_rdata;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d  = ERR_VALUE;
                    flag_d   = 1'b1;
                    toaddr_d = addr_q;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            flag_q   <= 1'b0;
            toaddr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rdata_q  <= rdata_d;
            flag_q   <= flag_d;
            toaddr_q <= toaddr_d;
        end
    end

    // valid/ready are decoded from the state register, so both drop
    // immediately on an asynchronous reset.
    assign s_req   = {(state_q == S_WAIT), addr_q, wdata_q, wstrb_q};
    assign m_resp  = {rdata_q, (state_q == S_RESP)};
    assign to_flag = flag_q;
    assign to_addr = toaddr_q;

endmodule

// File: tb/tb_pbus_timeout_bridge.sv
module tb_pbus_timeout_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk;
    logic          rst;
    logic [68:0]   m_req;
    logic [32:0]   m_resp;
    logic [68:0]   s_req;
    logic [32:0]   s_resp;
    logic          to_clr;
    logic          to_flag;
    logic [31:0]   to_addr;

    logic          m_valid;
    logic [31:0]   m_addr;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wstrb;
    logic          s_ready;
    logic [31:0]   s_rdata;

    int total;
    int bad;

    assign m_req  = {m_valid, m_addr, m_wdata, m_wstrb};
    assign s_resp = {s_rdata, s_ready};

    wire        o_s_valid = s_req[68];
    wire [31:0] o_s_addr  = s_req[67:36];
    wire [31:0] o_s_wdata = s_req[35:4];
    wire [3:0]  o_s_wstrb = s_req[3:0];
    wire        o_m_ready = m_resp[0];
    wire [31:0] o_m_rdata = m_resp[32:1];

    pbus_timeout_bridge #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TO),
        .ERR_VALUE (32'hDEAD_BEEF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_resp  (m_resp),
        .s_req   (s_req),
        .s_resp  (s_resp),
        .to_clr  (to_clr),
        .to_flag (to_flag),
        .to_addr (to_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        to_clr  = 1'b0;
        m_valid = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ready = 1'b0;
        s_rdata = '0;

        // ---------------- reset state
        step();
        step();
        chk("rst_s_valid", 64'(o_s_valid), 64'd0);
        chk("rst_m_ready", 64'(o_m_ready), 64'd0);
        chk("rst_m_rdata", 64'(o_m_rdata), 64'd0);
        chk("rst_s_addr",  64'(o_s_addr),  64'd0);
        chk("rst_s_wstrb", 64'(o_s_wstrb), 64'd0);
        chk("rst_to_flag", 64'(to_flag),   64'd0);
        chk("rst_to_addr", 64'(to_addr),   64'd0);
        rst = 1'b1;
        step();

        // ---------------- read, slave ready in first WAIT cycle
        m_valid = 1'b1; m_addr = 32'h0000_0100; m_wdata = '0; m_wstrb = 4'h0;
        chk("rd_c0_s_valid", 64'(o_s_valid), 64'd0);
        step();
        chk("rd_c1_s_valid", 64'(o_s_valid), 64'd1);
        chk("rd_c1_s_addr",  64'(o_s_addr),  64'h100);
        chk("rd_c1_s_wstrb", 64'(o_s_wstrb), 64'd0);
        chk("rd_c1_m_ready", 64'(o_m_ready), 64'd0);
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        step();
        chk("rd_c2_m_ready", 64'(o_m_ready), 64'd1);
        chk("rd_c2_m_rdata", 64'(o_m_rdata), 64'h1234_5678);
        chk("rd_c2_s_valid", 64'(o_s_valid), 64'd0);
        m_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
        step();
        chk("rd_c3_m_ready", 64'(o_m_ready), 64'd0);
        chk("rd_c3_m_rdata_hold", 64'(o_m_rdata), 64'h1234_5678);

        // ---------------- write, slave ready in third WAIT cycle
        m_valid = 1'b1; m_addr = 32'h0000_0010; m_wdata = 32'hA5A5_A5A5; m_wstrb = 4'hF;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("wr_s_valid", 64'(o_s_valid), 64'd1);
            chk("wr_s_addr",  64'(o_s_addr),  64'h10);
            chk("wr_s_wdata", 64'(o_s_wdata), 64'hA5A5_A5A5);
            chk("wr_s_wstrb", 64'(o_s_wstrb), 64'hF);
            chk("wr_m_ready", 64'(o_m_ready), 64'd0);
            if (i == 3) s_ready = 1'b1;
        end
        step();
        chk("wr_done_m_ready", 64'(o_m_ready), 64'd1);
        chk("wr_done_s_valid", 64'(o_s_valid), 64'd0);
        chk("wr_done_to_flag", 64'(to_flag),   64'd0);
        m_valid = 1'b0; m_wstrb = 4'h0; s_ready = 1'b0;
        step();
        chk("wr_after_m_ready", 64'(o_m_ready), 64'd0);

        // ---------------- timeout: slave never ready
        m_valid = 1'b1; m_addr = 32'h0000_0040; m_wdata = '0; m_wstrb = 4'h0;
        for (int i = 1; i <= TO; i++) begin
            step();
            chk("to_s_valid", 64'(o_s_valid), 64'd1);
            chk("to_m_ready", 64'(o_m_ready), 64'd0);
        end
        step();
        chk("to_done_m_ready", 64'(o_m_ready), 64'd1);
        chk("to_done_m_rdata", 64'(o_m_rdata), 64'hDEAD_BEEF);
        chk("to_done_s_valid", 64'(o_s_valid), 64'd0);
        chk("to_done_to_flag", 64'(to_flag),   64'd1);
        chk("to_done_to_addr", 64'(to_addr),   64'h40);
        m_valid = 1'b0;
        step();
        // late answer while idle must be ignored
        s_ready = 1'b1; s_rdata = 32'h5555_5555;
        step();
        chk("late_m_ready", 64'(o_m_ready), 64'd0);
        chk("late_s_valid", 64'(o_s_valid), 64'd0);
        s_ready = 1'b0; s_rdata = '0;
        step();
        chk("late2_m_ready", 64'(o_m_ready), 64'd0);
        chk("late2_m_rdata", 64'(o_m_rdata), 64'hDEAD_BEEF);

        // ---------------- to_clr alone
        to_clr = 1'b1;
        step();
        to_clr = 1'b0;
        chk("clr_to_flag", 64'(to_flag), 64'd0);
        chk("clr_to_addr", 64'(to_addr), 64'd0);

        // ---------------- ready in the last WAIT cycle wins over timeout
        m_valid = 1'b1; m_addr = 32'h0000_0080;
        for (int i = 1; i <= TO; i++) begin
            step();
            chk("edge_s_valid", 64'(o_s_valid), 64'd1);
            if (i == TO) begin
                s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
            end
        end
        step();
        chk("edge_m_ready", 64'(o_m_ready), 64'd1);
        chk("edge_m_rdata", 64'(o_m_rdata), 64'hCAFE_F00D);
        chk("edge_to_flag", 64'(to_flag),   64'd0);
        chk("edge_to_addr", 64'(to_addr),   64'd0);
        m_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
        step();

        // ---------------- timeout coinciding with to_clr: timeout wins
        m_valid = 1'b1; m_addr = 32'h0000_00C0;
        for (int i = 1; i <= TO; i++) begin
            step();
            if (i == TO) to_clr = 1'b1;
        end
        step();
        to_clr = 1'b0;
        chk("toclr_m_ready", 64'(o_m_ready), 64'd1);
        chk("toclr_m_rdata", 64'(o_m_rdata), 64'hDEAD_BEEF);
        chk("toclr_to_flag", 64'(to_flag),   64'd1);
        chk("toclr_to_addr", 64'(to_addr),   64'hC0);
        m_valid = 1'b0;
        step();

        // ---------------- reset mid-WAIT
        m_valid = 1'b1; m_addr = 32'h0000_0200;
        step();
        step();
        chk("mid_pre_s_valid", 64'(o_s_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_s_valid", 64'(o_s_valid), 64'd0);
        chk("mid_rst_m_ready", 64'(o_m_ready), 64'd0);
        chk("mid_rst_to_flag", 64'(to_flag),   64'd0);
        m_valid = 1'b0;
        step();
        chk("mid_hold_m_ready", 64'(o_m_ready), 64'd0);
        rst = 1'b1;
        m_valid = 1'b1; m_addr = 32'h0000_0300;
        step();
        chk("post_s_valid", 64'(o_s_valid), 64'd1);
        chk("post_s_addr",  64'(o_s_addr),  64'h300);
        s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
        step();
        chk("post_m_ready", 64'(o_m_ready), 64'd1);
        chk("post_m_rdata", 64'(o_m_rdata), 64'h0BAD_F00D);
        m_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
        step();

        // ---------------- back-to-back reads, one every 3 cycles
        for (int n = 0; n < 4; n++) begin
            chk("b2b_idle_m_ready", 64'(o_m_ready), 64'd0);
            m_valid = 1'b1; m_addr = 32'h0000_1000 + 32'(4 * n); m_wstrb = 4'h0;
            step();
            chk("b2b_s_valid", 64'(o_s_valid), 64'd1);
            chk("b2b_s_addr",  64'(o_s_addr),  64'(32'h0000_1000 + 32'(4 * n)));
            s_ready = 1'b1; s_rdata = 32'h1111_1111 * 32'(n + 1);
            step();
            chk("b2b_m_ready", 64'(o_m_ready), 64'd1);
            chk("b2b_m_rdata", 64'(o_m_rdata), 64'(32'h1111_1111 * 32'(n + 1)));
            m_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
            step();
        end
        chk("b2b_end_m_ready", 64'(o_m_ready), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
